// File: rtl/fft_reorder32.sv
// Bit-reversed to natural-order reorder buffer for a 32-point SDF FFT, using ping-pong banks and a valid/ready output.
// Optional macro IDX_OUT_EN adds idx_o, the natural index of the presented sample.
module fft_reorder32 #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_in_r,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_out_r,
    output logic [DATA_W-1:0] data_out_i,
    output logic              last_o,
    output logic              ovf_o
`ifdef IDX_OUT_EN
    ,
    output logic [LOG2N-1:0]  idx_o
`endif
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    logic [2*DATA_W-1:0] mem [0:2*N-1];

    logic [LOG2N-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic                wbank_q, wbank_d, rbank_q, rbank_d;
    logic [1:0]          full_q, full_d;
    logic                valid_q, valid_d, last_q, last_d, ovf_q, ovf_d;
    logic [2*DATA_W-1:0] data_q;
    logic [LOG2N-1:0]    wr_addr;
    logic                wr_en, advance;
`ifdef IDX_OUT_EN
    logic [LOG2N-1:0]    idx_q, idx_d;
`endif

    // Input arrives in bit-reversed order, so write at bitrev(wcnt) and read linearly.
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
        assign wr_addr[gi] = wcnt_q[LOG2N-1-gi];
    end

    always_comb begin
        wr_en   = valid_i && !full_q[wbank_q];
        advance = full_q[rbank_q] && (!valid_q || ready_i);
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        full_d  = full_q;
        valid_d = valid_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
`ifdef IDX_OUT_EN
        idx_d   = idx_q;
`endif
        if (wr_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == CNT_LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end
        if (valid_i && full_q[wbank_q]) begin
            ovf_d = 1'b1;
        end
        // Set and clear of full[] always hit different banks, so both apply.
        if (advance) begin
            valid_d = 1'b1;
            last_d  = (rcnt_q == CNT_LAST);
            rcnt_d  = rcnt_q + 1'b1;
`ifdef IDX_OUT_EN
            idx_d   = rcnt_q;
`endif
            if (rcnt_q == CNT_LAST) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank_q, wr_addr}] <= {data_in_r, data_in_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (advance) begin
            data_q <= mem[{rbank_q, rcnt_q}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef IDX_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
    assign idx_o = idx_q;
`endif

    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign ovf_o      = ovf_q;
    assign data_out_r = data_q[2*DATA_W-1:DATA_W];
    assign data_out_i = data_q[DATA_W-1:0];
endmodule
